rr_burst_arbiter: RTL and testbench

- Shares one downstream consumer between NUM_PORTS requesters, typically the outputs of per-flow fifo_base_bypass instances.
- Arbitration is round-robin; a granted requester keeps the grant for up to MAX_BURST consecutive transfers.
- Datapath is combinational (zero latency), matching first-word fall-through timing. Only arbitration state is registered.
- Sits between per-flow FIFOs and a shared pipeline stage or ranking unit.

---
 rtl/rr_burst_arbiter_if.sv | 28 ++
 rtl/rr_burst_arbiter.sv | 103 ++++++++++
 tb/tb_rr_burst_arbiter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_burst_arbiter_if.sv
// Requester-side and consumer-side handshake bundle for rr_burst_arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus downstream consumer.
interface rr_burst_arbiter_if #(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned DATA_WIDTH = 64
);
    localparam int unsigned ID_WIDTH = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0]  i__data_in_valid;
    logic [DATA_WIDTH-1:0] ia__data_in [NUM_PORTS];
    logic [NUM_PORTS-1:0]  o__data_in_ready;
    logic [NUM_PORTS-1:0]  i__port_mask;
    logic                  o__data_out_valid;
    logic [DATA_WIDTH-1:0] o__data_out;
    logic                  i__data_out_ready;
    logic [ID_WIDTH-1:0]   o__grant_id;
    logic                  o__burst_active;

    modport master (
        output i__data_in_valid, ia__data_in, i__port_mask, i__data_out_ready,
        input  o__data_in_ready, o__data_out_valid, o__data_out, o__grant_id, o__burst_active
    );

    modport slave (
        input  i__data_in_valid, ia__data_in, i__port_mask, i__data_out_ready,
        output o__data_in_ready, o__data_out_valid, o__data_out, o__grant_id, o__burst_active
    );
endinterface

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter with burst locking: zero-latency datapath from N requesters to one
// consumer; only the rotation pointer and the burst lock are registered.
module rr_burst_arbiter #(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic              clk,
    input  logic              reset,
    rr_burst_arbiter_if.slave bus
);
    localparam int unsigned ID_WIDTH  = $clog2(NUM_PORTS);
    localparam int unsigned CNT_WIDTH = $clog2(MAX_BURST + 1);
    localparam logic [ID_WIDTH-1:0]  LAST_ID   = ID_WIDTH'(NUM_PORTS - 1);
    localparam logic [CNT_WIDTH-1:0] BURST_MAX = CNT_WIDTH'(MAX_BURST);

    logic [ID_WIDTH-1:0]  r__rr_ptr;
    logic                 r__locked;
    logic [ID_WIDTH-1:0]  r__lock_id;
    logic [CNT_WIDTH-1:0] r__burst_cnt;

    logic [NUM_PORTS-1:0] req;
    logic                 lock_hit;
    logic [ID_WIDTH-1:0]  start_id;
    logic [31:0]          scan_idx;
    logic [ID_WIDTH-1:0]  sel;
    logic                 found;
    logic                 out_valid;
    logic [NUM_PORTS-1:0] in_ready;
    logic                 xfer;
    logic [CNT_WIDTH-1:0] cnt;

    // Explicit wrap so non-power-of-two port counts rotate correctly.
    function automatic logic [ID_WIDTH-1:0] wrap_inc(input logic [ID_WIDTH-1:0] id);
        return (id == LAST_ID) ? '0 : id + ID_WIDTH'(1);
    endfunction

    // Selection: keep the locked port while it still requests, else scan upward with wrap.
    always_comb begin
        req      = bus.i__data_in_valid & bus.i__port_mask;
        lock_hit = r__locked & req[r__lock_id];
        start_id = r__locked ? wrap_inc(r__lock_id) : r__rr_ptr;
        scan_idx = '0;
        sel      = '0;
        found    = 1'b0;
        if (lock_hit) begin
            sel   = r__lock_id;
            found = 1'b1;
        end else begin
            for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                scan_idx = 32'(start_id) + k;
                if (scan_idx >= NUM_PORTS) begin
                    scan_idx = scan_idx - NUM_PORTS;
                end
                if (!found && req[ID_WIDTH'(scan_idx)]) begin
                    sel   = ID_WIDTH'(scan_idx);
                    found = 1'b1;
                end
            end
        end
    end

    // Output drive; valid never looks at downstream ready.
    always_comb begin
        out_valid = found & ~reset;
        in_ready  = '0;
        if (out_valid) begin
            in_ready[sel] = bus.i__data_out_ready;
        end
        xfer = out_valid & bus.i__data_out_ready;
        cnt  = (r__locked && (sel == r__lock_id)) ? r__burst_cnt + CNT_WIDTH'(1) : CNT_WIDTH'(1);

        bus.o__data_out_valid = out_valid;
        bus.o__data_out       = out_valid ? bus.ia__data_in[sel] : '0;
        bus.o__grant_id       = out_valid ? sel : '0;
        bus.o__data_in_ready  = in_ready;
        bus.o__burst_active   = r__locked;
    end

    // Arbitration state: burst counting, lock release and pointer rotation.
    always_ff @(posedge clk) begin
        if (reset) begin
            r__rr_ptr    <= '0;
            r__locked    <= 1'b0;
            r__lock_id   <= '0;
            r__burst_cnt <= '0;
        end else if (xfer) begin
            if (cnt == BURST_MAX) begin
                r__locked    <= 1'b0;
                r__burst_cnt <= '0;
                r__rr_ptr    <= wrap_inc(sel);
            end else begin
                r__locked    <= 1'b1;
                r__lock_id   <= sel;
                r__burst_cnt <= cnt;
            end
        end else if (r__locked && !req[r__lock_id]) begin
            r__locked    <= 1'b0;
            r__burst_cnt <= '0;
            r__rr_ptr    <= wrap_inc(r__lock_id);
        end
    end
endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Bench for rr_burst_arbiter: three instances (MAX_BURST 2, 4, 1) share stimulus and are checked
// every cycle against a holder/served/turn model, plus directed literal expectations.
module tb_rr_burst_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned DW = 64;
    localparam int unsigned IW = 2;
    localparam int          NI = 3;

    logic clk = 1'b0;
    logic reset;
    logic [N-1:0] valid_v;
    logic [N-1:0] mask_v;
    logic         ready_v;
    int           seq [NI][N];

    always #5 clk = ~clk;

    function automatic logic [63:0] mk_data(input int k, input int p, input int s);
        return {8'(k), 8'(p), 16'h0000, 32'(s)};
    endfunction

    function automatic int mbf(input int k);
        return (k == 0) ? 2 : (k == 1) ? 4 : 1;
    endfunction

    rr_burst_arbiter_if #(.NUM_PORTS(N), .DATA_WIDTH(DW)) bus [NI] ();

    logic          o_valid  [NI];
    logic [DW-1:0] o_data   [NI];
    logic [N-1:0]  o_ready  [NI];
    logic [IW-1:0] o_grant  [NI];
    logic          o_active [NI];

    for (genvar k = 0; k < NI; k++) begin : g_dut
        localparam int unsigned MBK = (k == 0) ? 2 : (k == 1) ? 4 : 1;
        rr_burst_arbiter #(.NUM_PORTS(N), .DATA_WIDTH(DW), .MAX_BURST(MBK)) u_dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus[k].slave)
        );
        assign bus[k].i__data_in_valid  = valid_v;
        assign bus[k].i__port_mask      = mask_v;
        assign bus[k].i__data_out_ready = ready_v;
        for (genvar p = 0; p < N; p++) begin : g_src
            assign bus[k].ia__data_in[p] = mk_data(k, p, seq[k][p]);
        end
        assign o_valid[k]  = bus[k].o__data_out_valid;
        assign o_data[k]   = bus[k].o__data_out;
        assign o_ready[k]  = bus[k].o__data_in_ready;
        assign o_grant[k]  = bus[k].o__grant_id;
        assign o_active[k] = bus[k].o__burst_active;
    end

    // Model: who holds the grant, how many transfers it has had, whose turn is next.
    int holder [NI];
    int served [NI];
    int turn   [NI];
    bit known;

    int n_vec;
    int n_fail;

    // Last sampled DUT outputs, for the directed literal checks.
    logic          lv [NI];
    logic [DW-1:0] ld [NI];
    logic [N-1:0]  lr [NI];
    logic [IW-1:0] lg [NI];
    logic          la [NI];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic int pick(input int k, input logic [N-1:0] elig);
        int start;
        if (holder[k] >= 0 && elig[holder[k]]) return holder[k];
        start = (holder[k] >= 0) ? (holder[k] + 1) % N : turn[k];
        for (int j = 0; j < N; j++) begin
            if (elig[(start + j) % N]) return (start + j) % N;
        end
        return -1;
    endfunction

    task automatic cycle(input logic r, input logic [N-1:0] v, input logic [N-1:0] m, input logic rd);
        int            s   [NI];
        logic          ev  [NI];
        logic [DW-1:0] ed;
        logic [N-1:0]  er;
        logic [IW-1:0] eg;
        @(negedge clk);
        reset = r; valid_v = v; mask_v = m; ready_v = rd;
        #2;
        for (int k = 0; k < NI; k++) begin
            s[k] = r ? -1 : pick(k, v & m);
            ev[k] = (s[k] >= 0);
            ed = '0; er = '0; eg = '0;
            if (ev[k]) begin
                ed = mk_data(k, s[k], seq[k][s[k]]);
                eg = IW'(s[k]);
                if (rd) er[s[k]] = 1'b1;
            end
            lv[k] = o_valid[k]; ld[k] = o_data[k]; lr[k] = o_ready[k];
            lg[k] = o_grant[k]; la[k] = o_active[k];
            chk($sformatf("inst%0d valid", k), 64'(lv[k]), 64'(ev[k]));
            chk($sformatf("inst%0d grant", k), 64'(lg[k]), 64'(eg));
            chk($sformatf("inst%0d data", k), ld[k], ed);
            chk($sformatf("inst%0d ready", k), 64'(lr[k]), 64'(er));
            if (known) chk($sformatf("inst%0d burst_active", k), 64'(la[k]), 64'(holder[k] >= 0));
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            if (r) begin
                holder[k] = -1; served[k] = 0; turn[k] = 0;
            end else if (ev[k] && rd) begin
                seq[k][s[k]]++;
                if (s[k] == holder[k]) served[k]++;
                else begin holder[k] = s[k]; served[k] = 1; end
                if (served[k] == mbf(k)) begin
                    holder[k] = -1; served[k] = 0; turn[k] = (s[k] + 1) % N;
                end
            end else if (holder[k] >= 0 && !(v[holder[k]] && m[holder[k]])) begin
                turn[k] = (holder[k] + 1) % N; holder[k] = -1; served[k] = 0;
            end
        end
        if (r) known = 1'b1;
    endtask

    task automatic start_scenario();
        for (int k = 0; k < NI; k++) for (int p = 0; p < N; p++) seq[k][p] = 0;
        cycle(1'b1, 4'hF, 4'hF, 1'b1);
    endtask

    initial begin
        int            fair_exp [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
        int            brk_exp  [4]  = '{2, 2, 2, 3};
        int            msk_exp  [6]  = '{0, 1, 3, 0, 1, 3};
        logic [N-1:0]  tv [16] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010,
                                   4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b1001, 4'b1001,
                                   4'b1111, 4'b1111, 4'b0110, 4'b1111};
        logic [N-1:0]  tm [16] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF,
                                   4'hF, 4'b0110, 4'b0110, 4'hF, 4'hF, 4'b0001,
                                   4'hF, 4'hF, 4'hF, 4'hF};
        logic          tr [16] = '{1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1, 1, 1};
        logic [N-1:0]  ror;
        logic [DW-1:0] exp_d;

        n_vec = 0; n_fail = 0; known = 1'b0;
        reset = 1'b1; valid_v = '0; mask_v = '0; ready_v = 1'b0;
        for (int k = 0; k < NI; k++) begin
            holder[k] = -1; served[k] = 0; turn[k] = 0;
            for (int p = 0; p < N; p++) seq[k][p] = 0;
        end

        // Reset held two cycles, then MAX_BURST=2 fairness on instance 0.
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 4'hF, 4'hF, 1'b1);
            chk("reset valid", 64'(lv[0]), 64'd0);
            chk("reset ready", 64'(lr[0]), 64'd0);
        end
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 4'hF, 4'hF, 1'b1);
            chk($sformatf("fair grant %0d", i), 64'(lg[0]), 64'(fair_exp[i]));
            if (i == 0) chk("first ready", 64'(lr[0]), 64'h1);
            if (i == 2) chk("fair data p1", ld[0], mk_data(0, 1, 0));
            if (i == 8) chk("fair data p0", ld[0], mk_data(0, 0, 2));
        end

        // Backpressure with port 0 one transfer into its burst.
        start_scenario();
        cycle(1'b0, 4'b0101, 4'hF, 1'b1);
        exp_d = mk_data(0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 4'b0101, 4'hF, 1'b0);
            chk("bp valid", 64'(lv[0]), 64'd1);
            chk("bp grant", 64'(lg[0]), 64'd0);
            chk("bp ready", 64'(lr[0]), 64'd0);
            chk("bp data", ld[0], exp_d);
        end
        cycle(1'b0, 4'b0101, 4'hF, 1'b1);
        chk("bp release ready", 64'(lr[0]), 64'h1);
        cycle(1'b0, 4'b0101, 4'hF, 1'b1);
        chk("bp next grant", 64'(lg[0]), 64'd2);
        chk("bp next ready", 64'(lr[0]), 64'h4);

        // Broken lock on instance 1 (MAX_BURST=4).
        start_scenario();
        cycle(1'b0, 4'b0001, 4'hF, 1'b1);
        chk("brk first grant", 64'(lg[1]), 64'd0);
        cycle(1'b0, 4'b1100, 4'hF, 1'b1);
        chk("brk locked before", 64'(la[1]), 64'd1);
        chk("brk same cycle grant", 64'(lg[1]), 64'd2);
        chk("brk same cycle ready", 64'(lr[1]), 64'h4);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 4'b1100, 4'hF, 1'b1);
            chk($sformatf("brk grant %0d", i), 64'(lg[1]), 64'(brk_exp[i]));
            if (i == 0) chk("brk relocked", 64'(la[1]), 64'd1);
        end

        // Mask on instance 2 (MAX_BURST=1).
        start_scenario();
        ror = '0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 4'hF, 4'b1011, 1'b1);
            chk($sformatf("mask grant %0d", i), 64'(lg[2]), 64'(msk_exp[i]));
            ror = ror | lr[2];
        end
        chk("mask port2 ready", 64'(ror[2]), 64'd0);

        // Reset mid-burst on instance 1.
        start_scenario();
        cycle(1'b0, 4'b1000, 4'hF, 1'b1);
        cycle(1'b0, 4'b1000, 4'hF, 1'b1);
        chk("mid grant", 64'(lg[1]), 64'd3);
        cycle(1'b1, 4'b1010, 4'hF, 1'b1);
        chk("mid reset valid", 64'(lv[1]), 64'd0);
        chk("mid reset ready", 64'(lr[1]), 64'd0);
        cycle(1'b0, 4'b1010, 4'hF, 1'b1);
        chk("mid after active", 64'(la[1]), 64'd0);
        chk("mid after grant", 64'(lg[1]), 64'd1);
        chk("mid after ready", 64'(lr[1]), 64'h2);

        // Mixed directed table, checked by the model on all instances.
        start_scenario();
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, tv[i], tm[i], tr[i]);
            if (i < 6) chk($sformatf("single grant %0d", i), 64'(lg[1]), 64'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
